// File: rtl/rob_nwide_pkg.sv
// Purpose: shared types and default sizes for the reorder buffer slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rob_nwide_pkg;

    localparam int ROB_DEPTH     = 32;
    localparam int ROB_CDB_PORTS = 4;
    localparam int ROB_COMMIT_W  = 2;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_BR    = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } rob_op_t;

    // Fields captured at dispatch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd_addr;
        logic        regf_we;
        rob_op_t     op_type;
    } rob_alloc_t;

    // Fields delivered by a CDB writeback.
    typedef struct packed {
        logic [31:0] rd_data;
        logic        br_en;
        logic [31:0] pc_new;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rob_result_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        rob_alloc_t  info;
        rob_result_t res;
    } rob_entry_t;

endpackage

// File: rtl/rob_nwide_if.sv
// Purpose: bundles dispatch, CDB writeback and commit signals of the ROB.
// Latency: n/a (wiring only).
// Backpressure: enq_ready gates dispatch; commit_ack consumes commit slots.
// master = dispatch/CDB/commit side, slave = the ROB itself.
interface rob_nwide_if
    import rob_nwide_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int CDB_PORTS = ROB_CDB_PORTS,
    parameter int COMMIT_W  = ROB_COMMIT_W,
    parameter int IDX_W     = $clog2(DEPTH)
) ();

    logic                                flush;
    logic                                enq_valid;
    rob_alloc_t                          enq_info;
    logic                                enq_ready;
    logic [IDX_W-1:0]                    enq_idx;
    logic [CDB_PORTS-1:0]                cdb_valid;
    logic [CDB_PORTS-1:0][IDX_W-1:0]     cdb_idx;
    rob_result_t [CDB_PORTS-1:0]         cdb_res;
    logic [COMMIT_W-1:0]                 commit_valid;
    rob_entry_t [COMMIT_W-1:0]           commit_entry;
    logic [COMMIT_W-1:0]                 commit_ack;
    logic [IDX_W:0]                      count;
    logic                                full;
    logic                                empty;

    modport master (
        output flush, enq_valid, enq_info, cdb_valid, cdb_idx, cdb_res, commit_ack,
        input  enq_ready, enq_idx, commit_valid, commit_entry, count, full, empty
    );

    modport slave (
        input  flush, enq_valid, enq_info, cdb_valid, cdb_idx, cdb_res, commit_ack,
        output enq_ready, enq_idx, commit_valid, commit_entry, count, full, empty
    );

endinterface

// File: rtl/rob_nwide_retire_prefix.sv
// Purpose: commit_valid prefix over the head window and retire count from acks.
// Latency: combinational.
// Backpressure: acks after the first non-acked or non-ready slot are ignored.
// Ports: win_ready (valid & done per slot), ack, commit_valid, retire_cnt.
module rob_retire_prefix #(
    parameter int COMMIT_W = 2,
    parameter int RW       = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] win_ready,
    input  logic [COMMIT_W-1:0] ack,
    output logic [COMMIT_W-1:0] commit_valid,
    output logic [RW-1:0]       retire_cnt
);

    always_comb begin
        logic chain;
        logic taking;
        chain        = 1'b1;
        taking       = 1'b1;
        commit_valid = '0;
        retire_cnt   = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            chain           = chain & win_ready[k];
            commit_valid[k] = chain;
            taking          = taking & chain & ack[k];
            if (taking) begin
                retire_cnt = retire_cnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/rob_nwide.sv
// Purpose: N-wide reorder buffer: in-order alloc, multi-port CDB writeback, in-order retire.
// Latency: alloc and CDB writes visible one cycle later; no bypass into commit.
// Backpressure: enq_ready = !full from registered state only; commit_ack prefix retires.
// Ports: clk, rst (sync, active-high), rif (slave modport: dispatch, CDB, commit, status).
module rob_nwide
    import rob_nwide_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int CDB_PORTS = ROB_CDB_PORTS,
    parameter int COMMIT_W  = ROB_COMMIT_W,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    rob_nwide_if.slave  rif
);

    localparam int RW = $clog2(COMMIT_W + 1);

    rob_entry_t          ent [DEPTH];
    logic [IDX_W:0]      head;
    logic [IDX_W:0]      tail;
    logic [IDX_W:0]      cnt;
    logic                full_w;
    logic                alloc;
    logic [IDX_W-1:0]    win_idx [COMMIT_W];
    logic [COMMIT_W-1:0] win_ready;
    logic [RW-1:0]       retire_cnt;
    logic [IDX_W:0]      new_head;
    logic [DEPTH-1:0]    wb_hit;
    rob_result_t         wb_res [DEPTH];

    // Wrap bit makes full (indices equal, wrap differs) distinct from empty.
    assign cnt           = tail - head;
    assign full_w        = (cnt == (IDX_W+1)'(DEPTH));
    assign rif.count     = cnt;
    assign rif.full      = full_w;
    assign rif.empty     = (cnt == '0);
    assign rif.enq_ready = ~full_w;
    assign rif.enq_idx   = tail[IDX_W-1:0];

    assign alloc    = rif.enq_valid & ~full_w & ~rif.flush;
    assign new_head = head + (IDX_W+1)'(retire_cnt);

    // Head window: slots beyond tail read invalid entries, so no count masking needed.
    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            win_idx[k]          = head[IDX_W-1:0] + IDX_W'(k);
            win_ready[k]        = ent[win_idx[k]].valid & ent[win_idx[k]].done;
            rif.commit_entry[k] = ent[win_idx[k]];
        end
    end

    rob_retire_prefix #(
        .COMMIT_W (COMMIT_W),
        .RW       (RW)
    ) u_prefix (
        .win_ready    (win_ready),
        .ack          (rif.commit_ack),
        .commit_valid (rif.commit_valid),
        .retire_cnt   (retire_cnt)
    );

    // Per-entry port match; scanning high to low lets the lowest port win.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            wb_hit[e] = 1'b0;
            wb_res[e] = '0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (rif.cdb_valid[p] && (rif.cdb_idx[p] == IDX_W'(e))) begin
                    wb_hit[e] = 1'b1;
                    wb_res[e] = rif.cdb_res[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent[e] <= '0;
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (RW'(k) < retire_cnt) begin
                    ent[win_idx[k]].valid <= 1'b0;
                    ent[win_idx[k]].done  <= 1'b0;
                end
            end
            head <= new_head;
            if (rif.flush) begin
                for (int e = 0; e < DEPTH; e++) begin
                    ent[e].valid <= 1'b0;
                    ent[e].done  <= 1'b0;
                end
                tail <= new_head;
            end else begin
                // Retiring entries are already done, so these never collide with the clears above.
                for (int e = 0; e < DEPTH; e++) begin
                    if (wb_hit[e] && ent[e].valid && !ent[e].done) begin
                        ent[e].done <= 1'b1;
                        ent[e].res  <= wb_res[e];
                    end
                end
                // The tail slot is never valid when not full, so alloc cannot clash with writeback.
                if (alloc) begin
                    ent[tail[IDX_W-1:0]].valid <= 1'b1;
                    ent[tail[IDX_W-1:0]].done  <= 1'b0;
                    ent[tail[IDX_W-1:0]].info  <= rif.enq_info;
                    tail                       <= tail + (IDX_W+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_nwide.sv
// Purpose: self-checking bench for rob_nwide against a queue-based model.
// Latency: model advances one step per clock edge.
// Backpressure: model honours enq_ready and the commit_ack prefix rule.
module tb_rob_nwide;
    import rob_nwide_pkg::*;

    localparam int DEPTH = 32;
    localparam int CDB   = 4;
    localparam int CW    = 2;
    localparam int IDX_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_nwide_if #(.DEPTH(DEPTH), .CDB_PORTS(CDB), .COMMIT_W(CW), .IDX_W(IDX_W)) rif ();

    rob_nwide #(.DEPTH(DEPTH), .CDB_PORTS(CDB), .COMMIT_W(CW), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .rif (rif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: in-flight instructions in program order; q[0] is the head.
    typedef struct {
        rob_alloc_t  info;
        rob_result_t res;
        bit          done;
    } m_ent_t;

    m_ent_t q[$];
    int     m_head = 0;   // head pointer including wrap, 0..63
    bit     m_live = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic rob_alloc_t rand_info();
        rob_alloc_t a;
        a.pc      = $urandom;
        a.inst    = $urandom;
        a.rd_addr = 5'($urandom_range(0, 31));
        a.regf_we = 1'($urandom_range(0, 1));
        a.op_type = rob_op_t'(2'($urandom_range(0, 3)));
        return a;
    endfunction

    function automatic rob_result_t rand_res();
        rob_result_t r;
        r.rd_data   = $urandom;
        r.br_en     = 1'($urandom_range(0, 1));
        r.pc_new    = $urandom;
        r.mem_addr  = $urandom;
        r.mem_rmask = 4'($urandom_range(0, 15));
        r.mem_wmask = 4'($urandom_range(0, 15));
        r.mem_rdata = $urandom;
        r.mem_wdata = $urandom;
        return r;
    endfunction

    task automatic idle();
        rst            = 1'b0;
        rif.flush      = 1'b0;
        rif.enq_valid  = 1'b0;
        rif.enq_info   = '0;
        rif.cdb_valid  = '0;
        rif.cdb_idx    = '0;
        rif.cdb_res    = '0;
        rif.commit_ack = '0;
    endtask

    // Compare every output against the model (state-only outputs, sampled at negedge).
    task automatic compare_outputs();
        int  sz;
        bit  pre;
        bit  exp_v;
        rob_entry_t e;
        if (!m_live) return;
        sz = q.size();
        chk("count", rif.count, sz);
        chk("full", rif.full, sz == DEPTH);
        chk("empty", rif.empty, sz == 0);
        chk("enq_ready", rif.enq_ready, sz != DEPTH);
        chk("enq_idx", rif.enq_idx, (m_head + sz) % DEPTH);
        pre = 1'b1;
        for (int k = 0; k < CW; k++) begin
            exp_v = pre && (k < sz) && q[k].done;
            pre   = exp_v;
            chk("commit_valid", rif.commit_valid[k], exp_v);
            if (exp_v) begin
                e.valid = 1'b1;
                e.done  = 1'b1;
                e.info  = q[k].info;
                e.res   = q[k].res;
                chk("commit_entry", rif.commit_entry[k], e);
            end
        end
    endtask

    task automatic model_step();
        int sz;
        int r;
        int pos;
        m_ent_t ne;
        if (rst) begin
            q.delete();
            m_head = 0;
            m_live = 1;
            return;
        end
        if (!m_live) return;
        sz = q.size();
        r  = 0;
        for (int k = 0; k < CW; k++) begin
            if (r == k && k < sz && q[k].done && rif.commit_ack[k]) r++;
        end
        if (!rif.flush) begin
            for (int p = 0; p < CDB; p++) begin
                if (rif.cdb_valid[p]) begin
                    pos = (int'(rif.cdb_idx[p]) - (m_head % DEPTH) + DEPTH) % DEPTH;
                    if (pos < sz && !q[pos].done) begin
                        q[pos].done = 1;
                        q[pos].res  = rif.cdb_res[p];
                    end
                end
            end
        end
        for (int k = 0; k < r; k++) void'(q.pop_front());
        m_head = (m_head + r) % (2 * DEPTH);
        if (rif.flush) begin
            q.delete();
        end else if (rif.enq_valid && sz < DEPTH) begin
            ne.info = rif.enq_info;
            ne.res  = '0;
            ne.done = 0;
            q.push_back(ne);
        end
    endtask

    task automatic cycle();
        compare_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        idle();
    endtask

    task automatic alloc_n(int n);
        for (int i = 0; i < n; i++) begin
            idle();
            rif.enq_valid = 1'b1;
            rif.enq_info  = rand_info();
            cycle();
        end
        idle();
    endtask

    task automatic set_cdb(int p, int idx, logic [31:0] data);
        rob_result_t r;
        r                 = rand_res();
        r.rd_data         = data;
        rif.cdb_valid[p]  = 1'b1;
        rif.cdb_idx[p]    = IDX_W'(idx);
        rif.cdb_res[p]    = r;
    endtask

    logic [IDX_W-1:0] head_idx;

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_count", rif.count, 0);
        chk("rst_empty", rif.empty, 1);
        chk("rst_full", rif.full, 0);
        chk("rst_enq_ready", rif.enq_ready, 1);
        chk("rst_enq_idx", rif.enq_idx, 0);
        chk("rst_commit_valid", rif.commit_valid, 0);

        // Fill with no writeback
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_enq_idx", rif.enq_idx, i);
            idle();
            rif.enq_valid = 1'b1;
            rif.enq_info  = rand_info();
            cycle();
        end
        idle();
        chk("fill_full", rif.full, 1);
        chk("fill_enq_ready", rif.enq_ready, 0);
        chk("fill_count", rif.count, 32);
        chk("fill_commit_valid", rif.commit_valid, 0);

        // Out-of-order completion blocks in-order retirement
        do_reset();
        alloc_n(4);
        set_cdb(0, 2, 32'h22);
        cycle();
        idle();
        set_cdb(1, 0, 32'h11);
        cycle();
        idle();
        chk("gap_cv_before", rif.commit_valid, 2'b01);
        rif.commit_ack = 2'b11;
        cycle();
        idle();
        head_idx = rif.enq_idx - IDX_W'(rif.count);
        chk("gap_count", rif.count, 3);
        chk("gap_head", head_idx, 1);
        chk("gap_cv_after", rif.commit_valid, 2'b00);
        set_cdb(2, 1, 32'h33);
        cycle();
        idle();
        chk("gap_cv_resume", rif.commit_valid, 2'b11);

        // Same-entry conflict and duplicate writeback
        do_reset();
        alloc_n(6);
        set_cdb(0, 5, 32'hAAAA);
        set_cdb(3, 5, 32'h5555);
        cycle();
        idle();
        set_cdb(1, 5, 32'h1234);
        cycle();
        idle();
        for (int p = 0; p < 4; p++) set_cdb(p, p, 32'h100 + 32'(p));
        cycle();
        idle();
        set_cdb(0, 4, 32'h104);
        cycle();
        idle();
        rif.commit_ack = 2'b11;
        cycle();
        cycle();
        idle();
        chk("dup_cv", rif.commit_valid, 2'b11);
        chk("dup_rd_data", rif.commit_entry[1].res.rd_data, 32'hAAAA);
        rif.commit_ack = 2'b11;
        cycle();
        idle();
        chk("dup_empty", rif.empty, 1);

        // Full buffer draining 2/cycle while enqueuing 1/cycle, across the wrap
        do_reset();
        alloc_n(DEPTH);
        for (int c = 0; c < DEPTH / CDB; c++) begin
            for (int p = 0; p < CDB; p++) set_cdb(p, c * CDB + p, $urandom);
            cycle();
            idle();
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            rif.commit_ack = 2'b11;
            rif.enq_valid  = 1'b1;
            rif.enq_info   = rand_info();
            cycle();
            chk("drain_count", rif.count, 30 - i);
        end
        idle();
        head_idx = rif.enq_idx - IDX_W'(rif.count);
        chk("drain_head_wrap", head_idx, 0);
        chk("drain_enq_idx", rif.enq_idx, 15);

        // Flush with retirement and a dropped enqueue
        do_reset();
        alloc_n(6);
        set_cdb(0, 0, 32'h1);
        set_cdb(1, 1, 32'h2);
        cycle();
        idle();
        rif.flush      = 1'b1;
        rif.commit_ack = 2'b11;
        rif.enq_valid  = 1'b1;
        rif.enq_info   = rand_info();
        cycle();
        idle();
        chk("flush_count", rif.count, 0);
        chk("flush_empty", rif.empty, 1);
        chk("flush_tail", rif.enq_idx, 2);
        cycle();
        chk("flush_drop", rif.count, 0);

        // Ack with a leading gap retires nothing
        do_reset();
        alloc_n(2);
        set_cdb(0, 0, 32'h7);
        set_cdb(1, 1, 32'h8);
        cycle();
        idle();
        rif.commit_ack = 2'b10;
        cycle();
        idle();
        chk("ack10_count", rif.count, 2);
        chk("ack10_cv", rif.commit_valid, 2'b11);
        chk("ack10_tail", rif.enq_idx, 2);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            idle();
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            if ($urandom_range(0, 59) == 0) rif.flush = 1'b1;
            rif.enq_valid = ($urandom_range(0, 9) < 7);
            rif.enq_info  = rand_info();
            for (int p = 0; p < CDB; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    set_cdb(p, (m_head + $urandom_range(0, q.size() + 1)) % DEPTH, $urandom);
                end
            end
            rif.commit_ack = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            cycle();
        end
        idle();
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
